// File: rtl/cnt161_ctrl.sv
// Upstream control for a 74HC161-style 4-bit counter: debounced run/step
// buttons, modulo-N wrap via synchronous parallel load, saturating wrap tally.
//
// Ports:
//   clk       rising-edge system clock
//   MR        synchronous active-high reset
//   btn_run   raw run/stop button (asynchronous, bouncing)
//   btn_step  raw single-step button (asynchronous, bouncing)
//   ld_req    one-cycle request to reload load_val into the counter
//   mod_n     last count value before wrap
//   load_val  value loaded at init, on ld_req and at wrap
//   q_fb      counter Q feedback
//   tc_fb     counter TC feedback (used only for the wrap tally)
//   Cep, Cet  counter count enables
//   PE        counter parallel enable, active-low
//   D         counter parallel data (= load_val)
//   running   high while in RUN
//   wraps     saturating count of modulo wraps and natural rollovers
module cnt161_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = 5
) (
    input  logic       clk,
    input  logic       MR,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       ld_req,
    input  logic [3:0] mod_n,
    input  logic [3:0] load_val,
    input  logic [3:0] q_fb,
    input  logic       tc_fb,
    output logic       Cep,
    output logic       Cet,
    output logic       PE,
    output logic [3:0] D,
    output logic       running,
    output logic [7:0] wraps
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_STEP,
        S_RUN,
        S_LOAD
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Bit 0 is the run button, bit 1 the step button.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      lvl_q, lvl_d;
    logic [1:0]      lvl_p_q;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];
    logic [1:0]      pulse;

    state_t     state_q, state_d;
    logic       ret_run_q, ret_run_d;
    logic [7:0] wraps_q, wraps_d;
    logic       en, pe_n, wrap;

    // A level flips only after DB_CYCLES consecutive differing samples;
    // any matching sample restarts the run.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl_d[i] = lvl_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign pulse = lvl_q & ~lvl_p_q;

    always_comb begin
        state_d   = state_q;
        ret_run_d = ret_run_q;
        en        = 1'b0;
        pe_n      = 1'b1;
        wrap      = 1'b0;
        case (state_q)
            S_INIT: begin
                pe_n    = 1'b0;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (ld_req) begin
                    state_d   = S_LOAD;
                    ret_run_d = 1'b0;
                end else if (pulse[0]) begin
                    state_d = S_RUN;
                end else if (pulse[1]) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                en        = 1'b1;
                wrap      = (q_fb == mod_n);
                state_d   = ld_req ? S_LOAD : S_IDLE;
                ret_run_d = 1'b0;
            end
            S_RUN: begin
                en   = 1'b1;
                wrap = (q_fb == mod_n);
                if (ld_req) begin
                    state_d   = S_LOAD;
                    ret_run_d = 1'b1;
                end else if (pulse[0]) begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                pe_n    = 1'b0;
                state_d = ret_run_q ? S_RUN : S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
        if (wrap) begin
            pe_n = 1'b0;
        end
        // MR forces a quiet counter interface before the first edge too.
        if (MR) begin
            en   = 1'b0;
            pe_n = 1'b1;
            wrap = 1'b0;
        end
        wraps_d = wraps_q;
        if ((wrap || (tc_fb && en && pe_n)) && wraps_q != 8'hFF) begin
            wraps_d = wraps_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (MR) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            lvl_q     <= '0;
            lvl_p_q   <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            state_q   <= S_INIT;
            ret_run_q <= 1'b0;
            wraps_q   <= '0;
        end else begin
            sync1_q   <= {btn_step, btn_run};
            sync2_q   <= sync1_q;
            lvl_q     <= lvl_d;
            lvl_p_q   <= lvl_q;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
            state_q   <= state_d;
            ret_run_q <= ret_run_d;
            wraps_q   <= wraps_d;
        end
    end

    assign Cep     = en;
    assign Cet     = en;
    assign PE      = pe_n;
    assign D       = load_val;
    assign running = (state_q == S_RUN) && !MR;
    assign wraps   = wraps_q;

endmodule

// File: tb/tb_cnt161_ctrl.sv
// Directed bench for cnt161_ctrl with a 74HC161 behavioural model on the
// counter side (or directly driven q_fb/tc_fb for the table phase).
module tb_cnt161_ctrl;

    logic       clk = 1'b0;
    logic       MR = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_step = 1'b0;
    logic       ld_req = 1'b0;
    logic [3:0] mod_n = 4'd9;
    logic [3:0] load_val = 4'd5;
    logic [3:0] q_fb;
    logic       tc_fb;
    logic       Cep, Cet, PE, running;
    logic [3:0] D;
    logic [7:0] wraps;

    logic       use_model = 1'b1;
    logic [3:0] q_drv = 4'd0;
    logic       tc_drv = 1'b0;
    logic [3:0] cq = 4'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnt161_ctrl #(.DB_CYCLES(4), .DB_W(3)) dut (
        .clk(clk), .MR(MR), .btn_run(btn_run), .btn_step(btn_step),
        .ld_req(ld_req), .mod_n(mod_n), .load_val(load_val),
        .q_fb(q_fb), .tc_fb(tc_fb), .Cep(Cep), .Cet(Cet), .PE(PE),
        .D(D), .running(running), .wraps(wraps)
    );

    // 74HC161 model: load beats count, count needs both enables.
    always @(posedge clk) begin
        if (!PE) cq <= D;
        else if (Cep && Cet) cq <= cq + 4'd1;
    end

    assign q_fb  = use_model ? cq : q_drv;
    assign tc_fb = use_model ? ((cq == 4'hF) && Cet) : tc_drv;

    typedef struct {
        logic [3:0] q;
        logic [3:0] m;
        logic [3:0] lv;
        logic       tc;
        logic       pe;
        logic       inc;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_run(input logic want, input string name);
        int k;
        k = 0;
        while (running !== want && k < 12) begin
            tick();
            k++;
        end
        chk(name, running, want);
    endtask

    initial begin
        int n;
        int acc;

        tbl[0] = '{4'd0,  4'd9,  4'd0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{4'd9,  4'd9,  4'd0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{4'd8,  4'd9,  4'd3, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{4'd15, 4'd9,  4'd0, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{4'd15, 4'd15, 4'd0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{4'd12, 4'd5,  4'd7, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{4'd5,  4'd5,  4'd7, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{4'd14, 4'd15, 4'd2, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{4'd15, 4'd15, 4'd2, 1'b0, 1'b0, 1'b1};

        // Reset and init load
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_pe", PE, 1);
            chk("rst_en", {Cep, Cet}, 0);
            chk("rst_run", running, 0);
            chk("rst_wraps", wraps, 0);
        end
        chk("d_pass", D, 5);
        MR = 1'b0;
        #1;
        chk("init_pe", PE, 0);
        chk("init_en", {Cep, Cet}, 0);
        tick();
        chk("idle_pe", PE, 1);
        chk("init_q", cq, 5);

        // ld_req in IDLE loads 0
        load_val = 4'd0;
        ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        chk("load_pe", PE, 0);
        chk("load_en", {Cep, Cet}, 0);
        tick();
        chk("load_done_pe", PE, 1);
        chk("load_q", cq, 0);

        // Debounce: 3-sample glitch rejected
        btn_run = 1'b1;
        tick(3);
        btn_run = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (running) n++;
        end
        chk("glitch3", n, 0);

        // Toggling every 2 cycles for 20 cycles
        n = 0;
        for (int i = 0; i < 20; i++) begin
            btn_run = ((i % 4) < 2);
            tick();
            if (running) n++;
        end
        btn_run = 1'b0;
        tick(2);
        chk("toggle", n, 0);

        // Held high: level flips 4 samples after the 2-FF sync, RUN next
        btn_run = 1'b1;
        n = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (running) n++;
        end
        chk("db_early", n, 0);
        tick();
        chk("db_run", running, 1);

        // Modulo-10 run
        for (int i = 0; i < 20; i++) begin
            chk("mod10_q", cq, i % 10);
            chk("mod10_pe", PE, (i % 10) != 9);
            tick();
        end
        chk("mod10_wraps", wraps, 2);
        chk("mod10_q0", cq, 0);

        // Step ignored while running
        btn_step = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({running, Cep, Cet} != 3'b111) n++;
        end
        chk("step_in_run", n, 0);
        btn_step = 1'b0;
        tick(8);

        // ld_req in RUN: one LOAD cycle then RUN resumes
        ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        chk("rl_load", {PE, Cep, running}, 0);
        tick();
        chk("rl_resume", {running, Cep, Cet}, 3'b111);
        chk("rl_q", cq, 0);

        // Release gives no pulse; second press stops
        btn_run = 1'b0;
        tick(8);
        chk("release", running, 1);
        btn_run = 1'b1;
        wait_run(1'b0, "stop");
        btn_run = 1'b0;
        tick(8);

        // Single step from 3
        load_val = 4'd3;
        ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        tick();
        chk("step_q3", cq, 3);
        btn_step = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Cep && Cet) n++;
        end
        chk("step_once", n, 1);
        chk("step_q4", cq, 4);
        btn_step = 1'b0;
        tick(8);

        // ld_req coincides with run pulse in IDLE
        btn_run = 1'b1;
        tick(6);
        ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        chk("sim_load", {PE, running}, 0);
        tick();
        chk("sim_idle", {PE, Cep, running}, 3'b100);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (running) n++;
        end
        chk("sim_dropped", n, 0);
        btn_run = 1'b0;
        tick(8);

        // Reset, then table phase with driven feedback
        use_model = 1'b0;
        q_drv = 4'd0;
        tc_drv = 1'b0;
        MR = 1'b1;
        tick();
        chk("rst2_wraps", wraps, 0);
        MR = 1'b0;
        tick();
        btn_run = 1'b1;
        wait_run(1'b1, "tbl_run");
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            q_drv = tbl[i].q;
            mod_n = tbl[i].m;
            load_val = tbl[i].lv;
            tc_drv = tbl[i].tc;
            #1;
            chk($sformatf("tbl%0d_pe", i), PE, tbl[i].pe);
            chk($sformatf("tbl%0d_d", i), D, tbl[i].lv);
            tick();
            acc += tbl[i].inc;
            chk($sformatf("tbl%0d_wraps", i), wraps, acc);
        end

        // Full 16-step cycles, saturation
        use_model = 1'b1;
        mod_n = 4'd15;
        load_val = 4'd0;
        tick(16);
        chk("cyc16", wraps, acc + 1);
        tick(300 * 16);
        chk("sat", wraps, 255);
        tick(32);
        chk("sat_hold", wraps, 255);

        // Mid-run reset
        chk("pre_mr_run", running, 1);
        MR = 1'b1;
        tick();
        chk("mr_wraps", wraps, 0);
        chk("mr_out", {running, Cep, Cet, PE}, 4'b0001);
        MR = 1'b0;
        #1;
        chk("mr_init", {PE, Cep}, 0);
        tick();
        chk("mr_idle", {PE, running}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt161_ctrl.md
Name: cnt161_ctrl

Overview:
Upstream control stage for the 74HC161-style 4-bit counter block. It drives the counter's Cep/Cet/PE/D inputs and reads back its Q and TC. Two raw lab push-buttons are debounced to give run/stop and single-step control. Modulo-N wrap is produced by issuing a synchronous parallel load of load_val when the counter reaches mod_n, and a completed-wrap tally is kept.

Parameters:
DB_CYCLES, 16, consecutive identical synchronised samples needed before a debounced button level changes (>=2).
DB_W, 5, width of each debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
MR  input  1  reset, synchronous, active-high.
btn_run  input  1  raw run/stop button, asynchronous, bouncing.
btn_step  input  1  raw single-step button, asynchronous, bouncing.
ld_req  input  1  synchronous one-cycle request to reload load_val into the counter.
mod_n  input  4  last count value before wrap (0..15).
load_val  input  4  value loaded at init, on ld_req and at wrap.
q_fb  input  4  counter Q feedback.
tc_fb  input  1  counter TC feedback (wrap tally only).
Cep  output  1  counter count-enable P.
Cet  output  1  counter count-enable T.
PE  output  1  counter parallel-enable, active-low; 0 loads D on the next edge regardless of Cep/Cet.
D  output  4  counter parallel data = load_val (combinational pass-through).
running  output  1  1 while in RUN.
wraps  output  8  saturating count of modulo wraps.

Behaviour:
- Clock and reset: one clock, clk. MR is synchronous and active-high; it acts only at a clk rising edge.
- While MR=1: state=INIT; Cep=Cet=0; PE=1; running=0; wraps=0; all sync FFs, debounce levels and counters cleared to 0. D follows load_val at all times.
- Debounce, per button: 2-FF synchroniser feeds counter cnt. Sample != current level -> cnt++; otherwise cnt=0. When cnt reaches DB_CYCLES-1 and the sample still differs, the level flips and cnt=0.
- Debounce event: pulse = level & ~level_d, one cycle. A release produces no pulse.
- Debounce latency: raw high held from cycle k -> pulse in cycle k+1+DB_CYCLES. Any glitch shorter than DB_CYCLES samples is rejected.
- FSM state INIT: 1 cycle after MR falls. PE=0, Cep=Cet=0. Next state IDLE.
- FSM state IDLE: Cep=Cet=0, PE=1. run_pulse -> RUN. step_pulse -> STEP.
- FSM state STEP: exactly 1 cycle, Cep=Cet=1. Next state IDLE.
- FSM state RUN: Cep=Cet=1 every cycle; running=1. run_pulse -> IDLE. step_pulse is ignored.
- FSM state LOAD: entered from IDLE/RUN/STEP when ld_req=1. 1 cycle, PE=0, Cep=Cet=0. Next state is RUN if entered from RUN, otherwise IDLE.
- Priority: MR > ld_req > run_pulse > step_pulse. A pulse coinciding with ld_req is dropped, not queued. ld_req during INIT is ignored, since INIT already loads.
- Wrap: in STEP or RUN, if q_fb==mod_n then PE=0 that cycle and the counter loads load_val instead of incrementing.
- PE is combinational from the registered state and q_fb; no extra latency.
- mod_n=0 with load_val=0 holds the counter at 0.
- q_fb>mod_n (e.g. load_val>mod_n): the counter counts up to 15, then rolls over naturally, then wraps at mod_n.
- wraps: +1 on each cycle with a wrap load (PE=0 in STEP/RUN). Also +1 when tc_fb=1 with Cep=Cet=1 and PE=1, i.e. natural 15->0 rollover. Saturates at 255.
- Reset mid-operation: any state returns to INIT on the edge where MR=1; pending debounce progress is discarded.

Test Plan:
1. Reset, init load: MR=1 for 3 cycles, load_val=5. Required: PE=1 and Cep=Cet=0 during MR; PE=0 for exactly 1 cycle after MR falls; with the counter model attached, q_fb=5.
2. Debounce (DB_CYCLES=4): btn_run toggling every 2 cycles for 20 cycles, then held high. Required: no pulse during toggling; single pulse 5 cycles after stable high; running=1 on the next cycle.
3. Modulo-10 run: mod_n=9, load_val=0, RUN. Required: q_fb sequence 0..9,0..9; PE=0 exactly in cycles where q_fb=9; wraps=2 after 20 counts.
4. Single step: IDLE, one debounced btn_step. Required: Cep=Cet=1 for exactly one cycle; q_fb 3->4; btn_step while RUN leaves Cep=Cet=1 unchanged.
5. Simultaneous events: ld_req and run_pulse in the same IDLE cycle. Required: LOAD (PE=0, one cycle) then IDLE; running stays 0. ld_req in RUN -> one LOAD cycle, then RUN resumes.
6. Saturation and rollover, plus mid-run reset: mod_n=15, load_val=0, run 300 full rollovers. Required: wraps=255 and holds. MR=1 mid-run -> wraps=0 and state INIT next cycle.
